// File: rtl/window3x3_gen_pkg.sv
// Shared image-pipeline constants and pixel type for the 3x3 window front end.
package window3x3_gen_pkg;

  localparam int unsigned DefPixW  = 8;
  localparam int unsigned WIN_SIZE = 3;
  localparam int unsigned WIN_TAPS = WIN_SIZE * WIN_SIZE;

  typedef logic [DefPixW-1:0] pixel_t;

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel stream in, 3x3 window out; master drives pixels, slave produces windows.
interface window3x3_gen_if #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = 8
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             sof;
  logic [PIX_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic             win_valid;
  logic [XW-1:0]    win_x;
  logic [YW-1:0]    win_y;
  logic             eof;

  modport master (
    output pix_in, pix_valid, sof,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, win_x, win_y, eof
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, win_x, win_y, eof
  );
endinterface

// File: rtl/window3x3_gen_line_buffer.sv
// Single-port line store: combinational read, write on the same cycle (read-before-write).
module window3x3_gen_line_buffer #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Raster pixel stream to interior 3x3 neighbourhoods, one cycle after the bottom-right pixel.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = DefPixW
) (
  input logic             clk,
  input logic             rst,
  window3x3_gen_if.slave  bus
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] ColLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] RowLast = YW'(IMG_H - 1);
  localparam logic [XW-1:0] ColTwo  = XW'(2);
  localparam logic [YW-1:0] RowTwo  = YW'(2);

  logic [XW-1:0]    col_q, col_d, cur_col;
  logic [YW-1:0]    row_q, row_d, cur_row;
  logic [PIX_W-1:0] win_q [WIN_SIZE][WIN_SIZE];
  logic [PIX_W-1:0] win_d [WIN_SIZE][WIN_SIZE];
  logic             win_valid_q, win_valid_d;
  logic [XW-1:0]    win_x_q, win_x_d;
  logic [YW-1:0]    win_y_q, win_y_d;
  logic             eof_q, eof_d;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // Both previous lines share one store: upper half is line row-2, lower half line row-1.
  window3x3_gen_line_buffer #(
    .Depth (IMG_W),
    .Width (2 * PIX_W),
    .AddrW (XW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (bus.pix_valid),
    .addr  (cur_col),
    .wdata ({lb0_rd, bus.pix_in}),
    .rdata ({lb1_rd, lb0_rd})
  );

  always_comb begin
    cur_col     = bus.sof ? '0 : col_q;
    cur_row     = bus.sof ? '0 : row_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    eof_d       = 1'b0;
    if (bus.pix_valid) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + YW'(1);
      end else begin
        col_d = cur_col + XW'(1);
        row_d = cur_row;
      end
      win_d[0][0] = win_q[0][1];
      win_d[0][1] = win_q[0][2];
      win_d[0][2] = lb1_rd;
      win_d[1][0] = win_q[1][1];
      win_d[1][1] = win_q[1][2];
      win_d[1][2] = lb0_rd;
      win_d[2][0] = win_q[2][1];
      win_d[2][1] = win_q[2][2];
      win_d[2][2] = bus.pix_in;
      // Columns 0 and 1 still hold pixels from the previous line, so suppress them.
      if (cur_row >= RowTwo && cur_col >= ColTwo) begin
        win_valid_d = 1'b1;
        win_x_d     = cur_col - XW'(1);
        win_y_d     = cur_row - YW'(1);
        eof_d       = (cur_col == ColLast) && (cur_row == RowLast);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      eof_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.p1        = win_q[0][0];
  assign bus.p2        = win_q[0][1];
  assign bus.p3        = win_q[0][2];
  assign bus.p4        = win_q[1][0];
  assign bus.p5        = win_q[1][1];
  assign bus.p6        = win_q[1][2];
  assign bus.p7        = win_q[2][0];
  assign bus.p8        = win_q[2][1];
  assign bus.p9        = win_q[2][2];
  assign bus.win_valid = win_valid_q;
  assign bus.win_x     = win_x_q;
  assign bus.win_y     = win_y_q;
  assign bus.eof       = eof_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 5x4 image, checked against a frame-array model.
module tb_window3x3_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window3x3_gen_if #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) bus ();

  window3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int eof_cnt = 0;

  // Model: the current frame as a 2D array plus the raster position of the next pixel.
  logic [7:0]  img [H][W];
  int          mr = 0, mc = 0;
  bit          m_ok = 0, exp_valid = 0, exp_eof = 0, known = 0;
  logic [71:0] exp_p = '0;
  int          exp_x = 0, exp_y = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {a0[7:0], a1[7:0], a2[7:0], a3[7:0], a4[7:0], a5[7:0], a6[7:0], a7[7:0], a8[7:0]};
  endfunction

  function automatic logic [71:0] dut_win();
    return {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8, bus.p9};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mr = 0; mc = 0; exp_valid = 0; exp_eof = 0; exp_p = '0; known = 1; m_ok = 1;
    end else if (bus.pix_valid) begin
      if (bus.sof) begin
        mr = 0; mc = 0;
      end
      img[mr][mc] = bus.pix_in;
      if (mr >= 2 && mc >= 2) begin
        exp_p = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_p = {exp_p[63:0], img[mr-2+i][mc-2+j]};
        exp_valid = 1; exp_x = mc - 1; exp_y = mr - 1;
        exp_eof = (mr == H - 1) && (mc == W - 1);
        known = 1;
      end else begin
        exp_valid = 0; exp_eof = 0; known = 0;
      end
      mc++;
      if (mc == W) begin
        mc = 0; mr++;
        if (mr == H) mr = 0;
      end
    end else begin
      exp_valid = 0; exp_eof = 0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("win_valid", 72'(bus.win_valid), 72'(exp_valid));
      chk("eof", 72'(bus.eof), 72'(exp_eof));
      if (exp_valid) begin
        chk("window", dut_win(), exp_p);
        chk("win_x", 72'(bus.win_x), 72'(exp_x));
        chk("win_y", 72'(bus.win_y), 72'(exp_y));
      end else if (known) begin
        chk("held window", dut_win(), exp_p);
      end
      if (bus.win_valid) begin
        win_cnt++;
        if (bus.eof) eof_cnt++;
      end
    end
  end

  task automatic send(input int v, input bit s);
    bus.pix_in = v[7:0]; bus.sof = s; bus.pix_valid = 1'b1;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; bus.sof = 1'b0;
  endtask

  // A bubble; sof may be raised to show it is ignored without pix_valid.
  task automatic idle(input int n, input bit s);
    repeat (n) begin
      bus.sof = s;
      @(posedge clk); #1;
      bus.sof = 1'b0;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " window"}, dut_win(), '0);
    chk({name, " win_valid"}, 72'(bus.win_valid), '0);
    chk({name, " win_x"}, 72'(bus.win_x), '0);
    chk({name, " win_y"}, 72'(bus.win_y), '0);
    chk({name, " eof"}, 72'(bus.eof), '0);
  endtask

  task automatic chk_counts(input string name, input int wins, input int eofs);
    idle(1, 1'b0);
    chk({name, " window count"}, 72'(win_cnt), 72'(wins));
    chk({name, " eof count"}, 72'(eof_cnt), 72'(eofs));
    win_cnt = 0; eof_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
    idle(2, 1'b0);
    chk_zero("reset");
    rst = 1'b0;
    win_cnt = 0; eof_cnt = 0;

    // Plain frame 0..19.
    for (int i = 0; i < 20; i++) begin
      send(i, i == 0);
      if (i == 12) begin
        chk("first window", dut_win(), pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        chk("first win_x", 72'(bus.win_x), 72'(1));
        chk("first win_y", 72'(bus.win_y), 72'(1));
      end
      if (i == 19) begin
        chk("last window", dut_win(), pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        chk("last eof", 72'(bus.eof), 72'(1));
      end
    end
    chk_counts("frame", 6, 1);

    // Same frame with ~40% bubbles, some carrying an unqualified sof.
    for (int i = 0; i < 20; i++) begin
      while ($urandom_range(99) < 40) idle(1, 1'($urandom_range(1)));
      send(i, i == 0);
    end
    chk_counts("bubble frame", 6, 1);

    // Two back-to-back frames, no sof, values wrapping mod 256.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 20; i++) begin
        send(230 + 20 * f + i, 1'b0);
        if (f == 1 && i == 12)
          chk("second frame window", dut_win(), pack9(250, 251, 252, 255, 0, 1, 4, 5, 6));
      end
    chk_counts("two frames", 12, 2);

    // Reset mid-frame, then restart without sof.
    for (int i = 0; i < 9; i++) send(i, i == 0);
    rst = 1'b1;
    idle(1, 1'b0);
    chk_zero("mid reset");
    rst = 1'b0;
    win_cnt = 0; eof_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      send(100 + i, 1'b0);
      if (i == 12) begin
        chk("post-reset window", dut_win(), pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
        chk("post-reset win_x", 72'(bus.win_x), 72'(1));
        chk("post-reset win_y", 72'(bus.win_y), 72'(1));
      end
    end
    chk_counts("post-reset frame", 6, 1);

    // sof at pixel index 7 restarts the frame.
    for (int i = 0; i < 7; i++) send(i, i == 0);
    for (int k = 0; k < 20; k++) begin
      send(50 + k, k == 0);
      if (k == 11) chk("no stale windows", 72'(win_cnt), 72'(0));
      if (k == 12) chk("post-sof window", dut_win(), pack9(50, 51, 52, 55, 56, 57, 60, 61, 62));
    end
    chk_counts("post-sof frame", 6, 1);

    idle(2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Producer-side front end of the 3x3 convolution pipeline.
- Accepts a raster-order pixel stream, one pixel per valid cycle.
- Buffers two previous lines and emits a full 3x3 neighbourhood, p1..p9, to the multiply stage, where it pairs with coefficients c1..c9.
- Only interior windows are emitted (no border padding); the downstream pipeline has no backpressure.

Parameters:
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- PIX_W, 8, bits per pixel

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- pix_in  input  PIX_W  incoming pixel, raster order
- pix_valid  input  1  pix_in valid this cycle
- sof  input  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0)
- p1,p2,p3,p4,p5,p6,p7,p8,p9  output  PIX_W each  window, row-major: p1 = top-left (oldest line, oldest column), p9 = bottom-right (current pixel)
- win_valid  output  1  p1..p9 hold a new valid window this cycle
- win_x  output  clog2(IMG_W)  column of window centre
- win_y  output  clog2(IMG_H)  row of window centre
- eof  output  1  pulses with the last window of a frame

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - All outputs 0.
  - col/row counters 0.
  - Window shift registers 0.
  - Line-buffer contents undefined; never exposed, because of the gating rule below.
- Counters:
  - col advances on each accepted pixel (pix_valid=1).
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1), both wrap to 0; the next frame begins with no sof required.
- sof:
  - sof=1 with pix_valid=1 forces the current pixel to (0,0), regardless of counter state.
  - Counters then continue from (0,0).
  - sof without pix_valid is ignored.
- Line buffers:
  - Two buffers, LB0 (line row-1) and LB1 (line row-2), each IMG_W deep, addressed by col.
  - On an accepted pixel: read LB1[col] and LB0[col], then write LB1[col]<=LB0[col] and LB0[col]<=pix_in, read-before-write in the same cycle.
- Window shift:
  - On an accepted pixel, each window row shifts left by one column.
  - New right column = {LB1[col], LB0[col], pix_in} into {p3, p6, p9}.
- Gating:
  - win_valid=1 in the cycle after an accepted pixel with row>=2 and col>=2.
  - In that case win_x=col-1 and win_y=row-1.
  - Otherwise win_valid=0.
- Latency and gaps:
  - Latency is 1 cycle, from the accepted pixel to win_valid.
  - Bubbles (pix_valid=0) freeze counters, line buffers and window.
  - p1..p9 hold their last values while win_valid=0.
- Window count: exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- eof: asserted with win_valid when the source pixel is (IMG_W-1, IMG_H-1).
- Line boundary: windows with col<2 straddle the line wrap and are suppressed. The shift registers still shift, so they are correct by col=2.
- Reset mid-frame: the partial frame is discarded, and the next accepted pixel is (0,0).
- Simultaneous sof and counter wrap: sof wins.

Decomposition:
- Shared package (img_pkg):
  - PIX_W default
  - WIN_SIZE=3
  - WIN_TAPS=9
  - a pixel typedef
- Sub-module line_buffer:
  - parameterised depth/width, single port, read-before-write, synchronous.
  - Instantiated twice, or once with 2*PIX_W width storing {LB1, LB0}.
  - The read path must give data in the same cycle, so use a register array, or pre-fetch the address col+1 if implemented as synchronous RAM.

Test Plan:
- Params IMG_W=5, IMG_H=4. Stream pixels 0..19 (value = row*5+col) with sof on the first one. Required response:
  - First win_valid, 1 cycle after pixel 12: p1..p9 = 0,1,2,5,6,7,10,11,12; win_x=1, win_y=1.
  - Windows per frame = 6.
  - Last window: p1..p9 = 7,8,9,12,13,14,17,18,19; eof=1.
- Same stream with random pix_valid bubbles (~40%) -> identical window sequence. win_valid is never high without a preceding accepted pixel, and p1..p9 are stable during bubbles.
- Two back-to-back frames without a second sof -> the second frame's windows equal the first's, offset by +20 per pixel value (mod 256). No window straddles the frame boundary.
- Raise rst for 1 cycle mid-frame (after pixel 8), then restart at value 100 -> all outputs 0 during reset. The first window after reset is 100,101,102,105,106,107,110,111,112.
- sof asserted at pixel index 7 of a frame -> that pixel is treated as (0,0). The first window after it appears 12 accepted pixels later; nothing is emitted from the stale partial frame after the sof.
- Default params (640x480), random data vs. a reference model -> 638*478 = 304964 windows, all matching, with exactly one eof.
